dual_stream_issue_scheduler: RTL and testbench

//  Issue scheduler between two RISC-V instruction streams (hart 0, hart 1) and the single decode stage.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 52 +++++
 rtl/dual_stream_issue_scheduler.sv | 132 +++++++++++++
 tb/tb_dual_stream_issue_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the dual-stream issue scheduler:
// control-transfer opcodes, stream ids, per-stream state.
package arb_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_BR = 1'b1
  } strm_state_t;

  function automatic logic is_ctl(
    input logic [6:0] opc
  );
    return (opc == OPC_BRANCH) ||
           (opc == OPC_JAL) ||
           (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Per-stream command FIFO: push/pop/flush, full/empty, head word.
// Ports: clk, reset (async low), push/push_data, pop, flush, full, empty, head.
module cmd_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [XLEN-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [XLEN-1:0] mem [DEPTH];
  logic            wr_en;
  logic            rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A full FIFO may still take a word when the head leaves on the same edge.
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dual_stream_issue_scheduler.sv
// Round-robin issue of two hart command streams into one decode stage.
// Ports: clk, reset (async low), cmd/valid/ready x2, out_*, br_resolve/src/taken.
module dual_stream_issue_scheduler
  import arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cmd_0,
  input  logic            cmd_valid_0,
  output logic            cmd_ready_0,
  input  logic [XLEN-1:0] cmd_1,
  input  logic            cmd_valid_1,
  output logic            cmd_ready_1,
  output logic [XLEN-1:0] out_data,
  output logic            out_src,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            br_resolve,
  input  logic            br_src,
  input  logic            br_taken
);

  strm_state_t     st0;
  strm_state_t     st1;
  logic            last_grant;
  logic            full0;
  logic            full1;
  logic            empty0;
  logic            empty1;
  logic [XLEN-1:0] head0;
  logic [XLEN-1:0] head1;
  logic            res0;
  logic            res1;
  logic            flush0;
  logic            flush1;
  logic            push0;
  logic            push1;
  logic            elig0;
  logic            elig1;
  logic            gnt;
  logic            load;
  logic            pop0;
  logic            pop1;

  // A resolve only counts for a stream that is actually waiting.
  assign res0   = br_resolve && (br_src == SRC0) && (st0 == WAIT_BR);
  assign res1   = br_resolve && (br_src == SRC1) && (st1 == WAIT_BR);
  assign flush0 = res0 && br_taken;
  assign flush1 = res1 && br_taken;

  assign cmd_ready_0 = !full0 && !flush0;
  assign cmd_ready_1 = !full1 && !flush1;
  assign push0 = cmd_valid_0 && cmd_ready_0;
  assign push1 = cmd_valid_1 && cmd_ready_1;

  assign elig0 = !empty0 && (st0 == RUN);
  assign elig1 = !empty1 && (st1 == RUN);

  always_comb begin
    gnt = SRC0;
    unique case (1'b1)
      (elig0 && elig1):  gnt = !last_grant;
      (elig1 && !elig0): gnt = SRC1;
      default:           gnt = SRC0;
    endcase
  end

  assign load = (!out_valid || out_ready) && (elig0 || elig1);
  assign pop0 = load && (gnt == SRC0);
  assign pop1 = load && (gnt == SRC1);

  cmd_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (cmd_0),
    .pop       (pop0),
    .flush     (flush0),
    .full      (full0),
    .empty     (empty0),
    .head      (head0)
  );

  cmd_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (cmd_1),
    .pop       (pop1),
    .flush     (flush1),
    .full      (full1),
    .empty     (empty1),
    .head      (head1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st0        <= RUN;
      st1        <= RUN;
      last_grant <= SRC1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= SRC0;
    end else begin
      // Issue of a control transfer blocks the stream on the same edge.
      if (pop0 && is_ctl(head0[6:0])) st0 <= WAIT_BR;
      else if (res0)                  st0 <= RUN;

      if (pop1 && is_ctl(head1[6:0])) st1 <= WAIT_BR;
      else if (res1)                  st1 <= RUN;

      if (load) begin
        out_data   <= gnt ? head1 : head0;
        out_src    <= gnt;
        out_valid  <= 1'b1;
        last_grant <= gnt;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_stream_issue_scheduler.sv
// Scoreboard bench for dual_stream_issue_scheduler.
// Directed stimulus queues expected issues; a negedge monitor checks them.
module tb_dual_stream_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_0;
  logic        cmd_valid_0;
  logic        cmd_ready_0;
  logic [31:0] cmd_1;
  logic        cmd_valid_1;
  logic        cmd_ready_1;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_valid;
  logic        out_ready;
  logic        br_resolve;
  logic        br_src;
  logic        br_taken;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

  dual_stream_issue_scheduler #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_0       (cmd_0),
    .cmd_valid_0 (cmd_valid_0),
    .cmd_ready_0 (cmd_ready_0),
    .cmd_1       (cmd_1),
    .cmd_valid_1 (cmd_valid_1),
    .cmd_ready_1 (cmd_ready_1),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .br_resolve  (br_resolve),
    .br_src      (br_src),
    .br_taken    (br_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(int rd, int imm);
    return {12'(imm), 5'd0, 3'b000, 5'(rd), 7'b0010011};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string name, int max);
    int i = 0;
    while (q.size() != 0 && i < max) begin
      tick();
      i++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d issues still pending, expected 0",
               name, q.size());
    end
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got src %0d data %h, expected none",
                 out_src, out_data);
      end else begin
        mon_e = q.pop_front();
        chk("issue_src", 32'(out_src), 32'(mon_e.src));
        chk("issue_data", out_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    cmd_0       = '0;
    cmd_1       = '0;
    cmd_valid_0 = 1'b0;
    cmd_valid_1 = 1'b0;
    out_ready   = 1'b0;
    br_resolve  = 1'b0;
    br_src      = 1'b0;
    br_taken    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready0", 32'(cmd_ready_0), 32'd1);
    chk("rst_ready1", 32'(cmd_ready_1), 32'd1);
    tick();

    // 1: round-robin alternation, stream 0 first
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back({1'b0, addi(1, i)});
      q.push_back({1'b1, addi(2, i)});
      cmd_0 = addi(1, i);
      cmd_1 = addi(2, i);
      cmd_valid_0 = 1'b1;
      cmd_valid_1 = 1'b1;
      tick();
    end
    cmd_valid_0 = 1'b0;
    cmd_valid_1 = 1'b0;
    drain("t1_drain", 20);
    tick();

    // 2: BEQ blocks stream 0 until resolve
    q.push_back({1'b0, BEQ});
    q.push_back({1'b0, addi(3, 7)});
    cmd_valid_0 = 1'b1;
    cmd_0 = BEQ;
    tick();
    cmd_0 = addi(3, 7);
    tick();
    cmd_valid_0 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_blocked_valid", 32'(out_valid), 32'd0);
    end
    br_resolve = 1'b1;
    br_src = 1'b0;
    br_taken = 1'b0;
    tick();
    br_resolve = 1'b0;
    chk("t2_resolve_edge_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t2_resume_valid", 32'(out_valid), 32'd1);
    chk("t2_resume_data", out_data, addi(3, 7));
    drain("t2_drain", 10);

    // 3: taken resolve flushes prefetched words and drops concurrent push
    q.push_back({1'b0, JAL});
    cmd_valid_0 = 1'b1;
    cmd_0 = JAL;
    tick();
    for (int i = 0; i < 3; i++) begin
      cmd_0 = addi(4, 100 + i);
      tick();
    end
    cmd_valid_0 = 1'b0;
    tick();
    tick();
    br_resolve = 1'b1;
    br_src = 1'b0;
    br_taken = 1'b1;
    cmd_valid_0 = 1'b1;
    cmd_0 = addi(5, 55);
    #1;
    chk("t3_flush_ready", 32'(cmd_ready_0), 32'd0);
    tick();
    br_resolve = 1'b0;
    br_taken = 1'b0;
    cmd_valid_0 = 1'b0;
    chk("t3_post_flush_ready", 32'(cmd_ready_0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_flushed_valid", 32'(out_valid), 32'd0);
    end
    q.push_back({1'b0, addi(6, 66)});
    cmd_valid_0 = 1'b1;
    cmd_0 = addi(6, 66);
    tick();
    cmd_valid_0 = 1'b0;
    drain("t3_drain", 10);
    tick();

    // 4: stall with full FIFOs, no loss or reorder
    out_ready = 1'b0;
    q.push_back({1'b1, addi(8, 0)});
    for (int i = 0; i < 4; i++) begin
      q.push_back({1'b0, addi(7, i)});
      q.push_back({1'b1, addi(8, i + 1)});
    end
    for (int i = 0; i < 4; i++) begin
      cmd_0 = addi(7, i);
      cmd_1 = addi(8, i);
      cmd_valid_0 = 1'b1;
      cmd_valid_1 = 1'b1;
      tick();
    end
    cmd_valid_0 = 1'b0;
    cmd_valid_1 = 1'b0;
    chk("t4_full0_ready", 32'(cmd_ready_0), 32'd0);
    chk("t4_notfull1_ready", 32'(cmd_ready_1), 32'd1);
    cmd_valid_1 = 1'b1;
    cmd_1 = addi(8, 4);
    tick();
    cmd_valid_1 = 1'b0;
    chk("t4_full1_ready", 32'(cmd_ready_1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_data", out_data, addi(8, 0));
      chk("t4_stall_src", 32'(out_src), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    drain("t4_drain", 30);
    tick();

    // 5: same-cycle resolve of stream 1 and issue from stream 0
    q.push_back({1'b1, BEQ});
    q.push_back({1'b0, addi(9, 1)});
    q.push_back({1'b1, addi(10, 1)});
    q.push_back({1'b0, addi(9, 2)});
    cmd_valid_1 = 1'b1;
    cmd_1 = BEQ;
    tick();
    cmd_1 = addi(10, 1);
    tick();
    cmd_valid_1 = 1'b0;
    tick();
    tick();
    cmd_valid_0 = 1'b1;
    cmd_0 = addi(9, 1);
    tick();
    cmd_0 = addi(9, 2);
    br_resolve = 1'b1;
    br_src = 1'b1;
    br_taken = 1'b0;
    tick();
    cmd_valid_0 = 1'b0;
    br_resolve = 1'b0;
    tick();
    chk("t5_next_src", 32'(out_src), 32'd1);
    chk("t5_next_data", out_data, addi(10, 1));
    drain("t5_drain", 10);
    tick();

    // 6: mid-operation reset
    q.push_back({1'b1, JALR});
    cmd_valid_1 = 1'b1;
    cmd_1 = JALR;
    tick();
    cmd_valid_1 = 1'b0;
    drain("t6_jalr_drain", 10);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_0 = addi(11, i);
      cmd_1 = addi(12, i);
      cmd_valid_0 = 1'b1;
      cmd_valid_1 = 1'b1;
      tick();
    end
    cmd_valid_0 = 1'b0;
    cmd_valid_1 = 1'b0;
    tick();
    chk("t6_pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_src", 32'(out_src), 32'd0);
    q.delete();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    chk("t6_ready0", 32'(cmd_ready_0), 32'd1);
    q.push_back({1'b0, addi(13, 1)});
    q.push_back({1'b1, addi(14, 1)});
    cmd_0 = addi(13, 1);
    cmd_1 = addi(14, 1);
    cmd_valid_0 = 1'b1;
    cmd_valid_1 = 1'b1;
    tick();
    cmd_valid_0 = 1'b0;
    cmd_valid_1 = 1'b0;
    tick();
    chk("t6_first_src", 32'(out_src), 32'd0);
    chk("t6_first_valid", 32'(out_valid), 32'd1);
    drain("t6_drain", 10);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
